encoder_input_filter: RTL and testbench

Front-end conditioner for quadrature encoder pins, sitting directly upstream of the quadrature decoder core. It does three things:
- synchronises raw asynchronous A/B pins into the clk domain;
- rejects glitches shorter than a programmable number of cycles;
- flags illegal transitions, where both channels change on the same cycle.
Its filtered enc_a/enc_b outputs drive the decoder's enc_a/enc_b inputs one-to-one.

---
 rtl/encoder_input_filter_if.sv | 63 ++++++
 rtl/encoder_input_filter.sv | 148 ++++++++++++++
 tb/tb_encoder_input_filter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/encoder_input_filter_if.sv
// encoder_input_filter_if
//   Bundles the encoder pins, the filter configuration and the conditioned
//   outputs of encoder_input_filter.
//   Optional build macro: ENC_INDEX_EN adds the index channel signals.
//
//   enable      filter/monitor enable (synchroniser always runs)
//   filt_len    required stable cycles before an output changes (0 acts as 1)
//   clr_err     single-cycle clear of err_illegal, err_cnt, glitch_cnt
//   enc_a_raw   raw A pin, asynchronous
//   enc_b_raw   raw B pin, asynchronous
//   enc_a/b     filtered channel levels
//   edge_a/b    one-cycle pulse on the cycle enc_a/enc_b changes
//   err_illegal sticky flag: both channels changed on the same cycle
//   err_cnt     saturating illegal-transition count
//   glitch_cnt  saturating rejected-glitch count
//   enc_i_raw, enc_i, index_pulse  index channel (ENC_INDEX_EN only)
//
//   master: drives pins/config (system side), slave: the filter itself.

interface encoder_input_filter_if #(
   parameter int FLT_W = 8,
   parameter int ERR_W = 16
);
   logic             enable;
   logic [FLT_W-1:0] filt_len;
   logic             clr_err;
   logic             enc_a_raw;
   logic             enc_b_raw;
   logic             enc_a;
   logic             enc_b;
   logic             edge_a;
   logic             edge_b;
   logic             err_illegal;
   logic [ERR_W-1:0] err_cnt;
   logic [ERR_W-1:0] glitch_cnt;
`ifdef ENC_INDEX_EN
   logic             enc_i_raw;
   logic             enc_i;
   logic             index_pulse;

   modport master (
      output enable, filt_len, clr_err, enc_a_raw, enc_b_raw, enc_i_raw,
      input  enc_a, enc_b, edge_a, edge_b, err_illegal, err_cnt, glitch_cnt,
             enc_i, index_pulse
   );

   modport slave (
      input  enable, filt_len, clr_err, enc_a_raw, enc_b_raw, enc_i_raw,
      output enc_a, enc_b, edge_a, edge_b, err_illegal, err_cnt, glitch_cnt,
             enc_i, index_pulse
   );
`else
   modport master (
      output enable, filt_len, clr_err, enc_a_raw, enc_b_raw,
      input  enc_a, enc_b, edge_a, edge_b, err_illegal, err_cnt, glitch_cnt
   );

   modport slave (
      input  enable, filt_len, clr_err, enc_a_raw, enc_b_raw,
      output enc_a, enc_b, edge_a, edge_b, err_illegal, err_cnt, glitch_cnt
   );
`endif
endinterface

// File: rtl/encoder_input_filter.sv
// encoder_input_filter
//   Conditions quadrature encoder pins for the decoder core: synchronises
//   the raw pins into clk, rejects pulses shorter than filt_len cycles and
//   flags cycles where A and B change together.
//   Optional build macro: ENC_INDEX_EN adds a filtered index channel and
//   index_pulse (index rising while enc_a = enc_b = 1).
//
//   clk    system clock
//   reset  synchronous, active-high
//   bus    encoder_input_filter_if.slave (pins, config, filtered outputs)
//
//   Parameters: SYNC_STAGES (2..4) synchroniser depth, FLT_W filter length /
//   stability counter width, ERR_W error counter width.

module encoder_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FLT_W       = 8,
   parameter int ERR_W       = 16
) (
   input logic                  clk,
   input logic                  reset,
   encoder_input_filter_if.slave bus
);

   // Channels are handled as a small array: 0 = A, 1 = B, 2 = index.
`ifdef ENC_INDEX_EN
   localparam int NCH = 3;
`else
   localparam int NCH = 2;
`endif

   logic [NCH-1:0]         raw;
   logic [SYNC_STAGES-1:0] sync_q [NCH];
   logic [FLT_W-1:0]       cnt_q  [NCH];
   logic [NCH-1:0]         s;
   logic [NCH-1:0]         enc_q;
   logic [NCH-1:0]         enc_next;
   logic [NCH-1:0]         edge_q;
   logic [NCH-1:0]         diff;
   logic [NCH-1:0]         upd;
   logic [NCH-1:0]         abort;
   logic [FLT_W-1:0]       lm1;
   logic [1:0]             n_abort;
   logic                   illegal;
   logic                   err_q;
   logic [ERR_W-1:0]       err_cnt_q;
   logic [ERR_W-1:0]       glitch_cnt_q;
   logic [ERR_W-1:0]       err_base;
   logic [ERR_W-1:0]       glitch_base;
   logic [ERR_W-1:0]       err_cnt_next;
   logic [ERR_W-1:0]       glitch_cnt_next;
   logic [ERR_W:0]         err_sum;
   logic [ERR_W+1:0]       glitch_sum;

   assign raw[0] = bus.enc_a_raw;
   assign raw[1] = bus.enc_b_raw;
`ifdef ENC_INDEX_EN
   assign raw[2] = bus.enc_i_raw;
`endif

   always_comb begin
      s        = '0;
      diff     = '0;
      upd      = '0;
      abort    = '0;
      enc_next = enc_q;
      n_abort  = '0;
      // Terminal count is L-1 with L = max(filt_len,1).
      lm1 = (bus.filt_len == '0) ? '0 : bus.filt_len - FLT_W'(1);
      for (int c = 0; c < NCH; c++) begin
         s[c]    = sync_q[c][SYNC_STAGES-1];
         diff[c] = s[c] ^ enc_q[c];
         // ">=" rather than "==" so that shrinking filt_len mid-count
         // releases the output on the next differing edge.
         upd[c]   = bus.enable && diff[c] && (cnt_q[c] >= lm1);
         abort[c] = bus.enable && !diff[c] && (cnt_q[c] != '0);
         if (upd[c]) begin
            enc_next[c] = s[c];
         end
         n_abort = n_abort + 2'(abort[c]);
      end

      illegal = upd[0] & upd[1];

      // A clear on the same edge as a new event leaves only the new event.
      err_base     = bus.clr_err ? '0 : err_cnt_q;
      err_sum      = {1'b0, err_base} + (ERR_W+1)'(illegal);
      err_cnt_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

      glitch_base     = bus.clr_err ? '0 : glitch_cnt_q;
      glitch_sum      = {2'b00, glitch_base} + (ERR_W+2)'(n_abort);
      glitch_cnt_next = (|glitch_sum[ERR_W+1:ERR_W]) ? '1 : glitch_sum[ERR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            sync_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
         enc_q        <= '0;
         edge_q       <= '0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
         glitch_cnt_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
            if (!bus.enable || upd[c] || !diff[c]) begin
               cnt_q[c] <= '0;
            end else begin
               cnt_q[c] <= cnt_q[c] + FLT_W'(1);
            end
         end
         enc_q        <= enc_next;
         edge_q       <= upd;
         err_q        <= illegal | (err_q & ~bus.clr_err);
         err_cnt_q    <= err_cnt_next;
         glitch_cnt_q <= glitch_cnt_next;
      end
   end

   assign bus.enc_a       = enc_q[0];
   assign bus.enc_b       = enc_q[1];
   assign bus.edge_a      = edge_q[0];
   assign bus.edge_b      = edge_q[1];
   assign bus.err_illegal = err_q;
   assign bus.err_cnt     = err_cnt_q;
   assign bus.glitch_cnt  = glitch_cnt_q;

`ifdef ENC_INDEX_EN
   logic idx_q;

   // Qualify with the post-update A/B levels so the pulse lines up with
   // the cycle on which enc_i is first seen high.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= 1'b0;
      end else begin
         idx_q <= upd[2] & s[2] & enc_next[0] & enc_next[1];
      end
   end

   assign bus.enc_i       = enc_q[2];
   assign bus.index_pulse = idx_q;
`endif

endmodule

// File: tb/tb_encoder_input_filter.sv
// tb_encoder_input_filter
//   Step table (raw levels, enable, filt_len, clr_err timing, expected
//   output latency and end-of-step counter values) expanded per cycle into
//   a scoreboard queue; a monitor pops and compares #1 after each edge.
//   Error counters use ERR_W=3 so saturation is reachable.

module tb_encoder_input_filter;

   localparam int ERR_W = 3;
   localparam int NONE  = 99;
   localparam int NSTEP = 25;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   encoder_input_filter_if #(.FLT_W(8), .ERR_W(ERR_W)) bus ();

   encoder_input_filter #(
      .SYNC_STAGES(2),
      .FLT_W(8),
      .ERR_W(ERR_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   typedef struct {
      logic             a;
      logic             b;
      logic             en;
      logic [7:0]       flen;
      int               clr_at;
      int               n;
      int               lat_a;
      int               lat_b;
      logic             x_ill;
      logic [ERR_W-1:0] x_ecnt;
      logic [ERR_W-1:0] x_gcnt;
   } step_t;

   typedef struct {
      int               tag;
      logic             chk_cnt;
      logic             enc_a;
      logic             enc_b;
      logic             edge_a;
      logic             edge_b;
      logic             ill;
      logic [ERR_W-1:0] ecnt;
      logic [ERR_W-1:0] gcnt;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   exp_t  drv_e;
   step_t tbl[NSTEP];
   logic  ea;
   logic  eb;
   int    n_vec = 0;
   int    n_mis = 0;

   function automatic step_t mk(logic a, logic b, logic en, int flen, int clr_at,
                                int n, int la, int lb, logic ill, int ec, int gc);
      step_t t;
      t.a = a; t.b = b; t.en = en; t.flen = 8'(flen); t.clr_at = clr_at;
      t.n = n; t.lat_a = la; t.lat_b = lb;
      t.x_ill = ill; t.x_ecnt = ERR_W'(ec); t.x_gcnt = ERR_W'(gc);
      return t;
   endfunction

   task automatic cmp(string name, int tag, logic [7:0] act, logic [7:0] exp);
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s step %0d: got %0d, want %0d", name, tag, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_vec++;
         cmp("enc_a",  mon_e.tag, 8'(bus.enc_a),  8'(mon_e.enc_a));
         cmp("enc_b",  mon_e.tag, 8'(bus.enc_b),  8'(mon_e.enc_b));
         cmp("edge_a", mon_e.tag, 8'(bus.edge_a), 8'(mon_e.edge_a));
         cmp("edge_b", mon_e.tag, 8'(bus.edge_b), 8'(mon_e.edge_b));
         if (mon_e.chk_cnt) begin
            cmp("err_illegal", mon_e.tag, 8'(bus.err_illegal), 8'(mon_e.ill));
            cmp("err_cnt",     mon_e.tag, 8'(bus.err_cnt),     8'(mon_e.ecnt));
            cmp("glitch_cnt",  mon_e.tag, 8'(bus.glitch_cnt),  8'(mon_e.gcnt));
         end
      end
   end

   initial begin
      //              a  b  en fl clr  n   la    lb    ill ec gc
      tbl[0]  = mk(1, 1, 1, 1, -1, 4,  2,    2,    1, 1, 0); // release from reset, A+B together
      tbl[1]  = mk(1, 1, 1, 4,  0, 2,  NONE, NONE, 0, 0, 0); // clr_err
      tbl[2]  = mk(0, 1, 1, 1, -1, 4,  2,    NONE, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 1, -1, 4,  NONE, 2,    0, 0, 0);
      tbl[4]  = mk(1, 0, 1, 4, -1, 3,  NONE, NONE, 0, 0, 0); // 3-cycle pulse on A
      tbl[5]  = mk(0, 0, 1, 4, -1, 6,  NONE, NONE, 0, 0, 1); //   rejected
      tbl[6]  = mk(1, 0, 1, 4, -1, 10, 5,    NONE, 0, 0, 1); // clean step, L=4
      tbl[7]  = mk(0, 0, 1, 0, -1, 4,  2,    NONE, 0, 0, 1); // filt_len 0 acts as 1
      tbl[8]  = mk(1, 1, 1, 1, -1, 4,  2,    2,    1, 1, 1); // illegal
      tbl[9]  = mk(0, 0, 1, 1,  2, 4,  2,    2,    1, 1, 0); // clr on the illegal edge
      tbl[10] = mk(0, 1, 0, 4, -1, 20, NONE, NONE, 1, 1, 0); // disabled, B steps
      tbl[11] = mk(0, 1, 1, 4, -1, 6,  NONE, 3,    1, 1, 0); // re-enable: full L
      tbl[12] = mk(1, 1, 1, 8, -1, 5,  NONE, NONE, 1, 1, 0); // count to 3 with L=8
      tbl[13] = mk(1, 1, 1, 2, -1, 3,  0,    NONE, 1, 1, 0); // shrink L: immediate
      tbl[14] = mk(0, 0, 1, 4, -1, 3,  NONE, NONE, 1, 1, 0); // both channels glitch
      tbl[15] = mk(1, 1, 1, 4, -1, 6,  NONE, NONE, 1, 1, 2);
      tbl[16] = mk(0, 0, 1, 4, -1, 3,  NONE, NONE, 1, 1, 2);
      tbl[17] = mk(1, 1, 1, 4, -1, 6,  NONE, NONE, 1, 1, 4);
      tbl[18] = mk(0, 0, 1, 4, -1, 3,  NONE, NONE, 1, 1, 4);
      tbl[19] = mk(1, 1, 1, 4, -1, 6,  NONE, NONE, 1, 1, 6);
      tbl[20] = mk(0, 0, 1, 4, -1, 3,  NONE, NONE, 1, 1, 6);
      tbl[21] = mk(1, 1, 1, 4, -1, 6,  NONE, NONE, 1, 1, 7); // +2 saturates at 7
      tbl[22] = mk(0, 1, 1, 4, -1, 3,  NONE, NONE, 1, 1, 7); // A starts counting
      tbl[23] = mk(0, 1, 0, 4, -1, 2,  NONE, NONE, 1, 1, 7); //   interrupted
      tbl[24] = mk(0, 1, 1, 4, -1, 6,  3,    NONE, 1, 1, 7); //   restarts from 0

      reset         = 1'b1;
      bus.enable    = 1'b1;
      bus.filt_len  = 8'd1;
      bus.clr_err   = 1'b0;
      bus.enc_a_raw = 1'b1;
      bus.enc_b_raw = 1'b1;
`ifdef ENC_INDEX_EN
      bus.enc_i_raw = 1'b0;
`endif

      // Reset held with both pins high: everything reads 0.
      for (int i = 0; i < 3; i++) begin
         drv_e = '{tag: -1, chk_cnt: 1'b1, enc_a: 1'b0, enc_b: 1'b0, edge_a: 1'b0,
                   edge_b: 1'b0, ill: 1'b0, ecnt: '0, gcnt: '0};
         sb.push_back(drv_e);
         @(posedge clk);
         #3;
      end
      reset = 1'b0;
      ea = 1'b0;
      eb = 1'b0;

      for (int si = 0; si < NSTEP; si++) begin
         bus.enc_a_raw = tbl[si].a;
         bus.enc_b_raw = tbl[si].b;
         bus.enable    = tbl[si].en;
         bus.filt_len  = tbl[si].flen;
         for (int j = 0; j < tbl[si].n; j++) begin
            bus.clr_err    = (j == tbl[si].clr_at);
            drv_e.tag      = si;
            drv_e.enc_a    = (j >= tbl[si].lat_a) ? tbl[si].a : ea;
            drv_e.enc_b    = (j >= tbl[si].lat_b) ? tbl[si].b : eb;
            drv_e.edge_a   = (j == tbl[si].lat_a);
            drv_e.edge_b   = (j == tbl[si].lat_b);
            drv_e.chk_cnt  = (j == tbl[si].n - 1);
            drv_e.ill      = tbl[si].x_ill;
            drv_e.ecnt     = tbl[si].x_ecnt;
            drv_e.gcnt     = tbl[si].x_gcnt;
            sb.push_back(drv_e);
            @(posedge clk);
            #3;
         end
         if (tbl[si].lat_a < tbl[si].n) ea = tbl[si].a;
         if (tbl[si].lat_b < tbl[si].n) eb = tbl[si].b;
      end
      bus.clr_err = 1'b0;

      repeat (3) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         n_mis++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
